port_sequencer: RTL and testbench
=================================

PORT_SEQUENCER -- requirements
Module: port_sequencer

Interface
REQ-001 Parameter STEPS, default 8, number of pattern table entries (fixed at 8 for this release).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 chipSelect  in  1  CPU bus select for this block.
REQ-005 writeEnable  in  1  CPU write strobe, qualified by chipSelect.
REQ-006 address  in  5  CPU word address.
REQ-007 dataIn  in  32  CPU write data.
REQ-008 dataOut  out  32  CPU read data, combinational on address.
REQ-009 portChipSelect  out  1  select to the digital port.
REQ-010 portWriteIO  out  1  port value write strobe.
REQ-011 portWriteDirection  out  1  port direction write strobe.
REQ-012 portDataOut  out  32  data to the port's dataIn.
REQ-013 portDataIn  in  32  pin state from the port's dataOut.
REQ-014 busy  out  1  high while the sequence runs.
REQ-015 irq  out  1  equals the done flag.

Function
REQ-016 Register map SHALL be: 0 CTRL, 1 LENGTH[3:0], 2 DIRECTION[31:0], 3 SAMPLE (read-only), 8-15 VALUE[0..7][31:0], 16-23 DELAY[0..7][15:0]; other addresses read 0 and ignore writes.
REQ-017 CTRL write: bit0 start, bit1 loop (stored), bit2 abort; any CTRL write SHALL clear done.
REQ-018 CTRL read: bit0 busy, bit1 done, bit2 loop, bits6:4 current step; other bits 0.
REQ-019 States SHALL be IDLE, DIR, WRITE, WAIT.
REQ-020 IDLE: start with LENGTH != 0 -> DIR, latching effective length = min(LENGTH, 8) and step = 0; start with LENGTH == 0 ignored.
REQ-021 DIR (1 cycle): portChipSelect=1, portWriteDirection=1, portDataOut=DIRECTION -> WRITE.
REQ-022 WRITE (1 cycle): portChipSelect=1, portWriteIO=1, portDataOut=VALUE[step]; counter <= DELAY[step]; SAMPLE <= portDataIn -> WAIT.
REQ-023 WAIT: counter != 0 -> decrement; counter == 0 -> advance.
REQ-024 Advance: step < length-1 -> step+1, WRITE; last step with loop=1 -> step=0, WRITE; last step with loop=0 -> IDLE, done set.
REQ-025 Consecutive port writes SHALL be spaced DELAY+2 cycles; DELAY=0 gives a 2-cycle spacing.
REQ-026 Port strobes SHALL be 0 and portDataOut SHALL be 0 in IDLE and WAIT.
REQ-027 busy SHALL be 1 in DIR, WRITE, WAIT.
REQ-028 Abort (any state) SHALL force IDLE next cycle, done stays 0, no port strobe that cycle; abort wins over start in the same write.
REQ-029 Start while busy SHALL be ignored (loop bit still updated).
REQ-030 VALUE/DELAY writes while busy SHALL be accepted and used at that entry's next WRITE; LENGTH/DIRECTION writes take effect at next start.
REQ-031 Clearing loop while looping SHALL end the sequence after the current last step.

Reset
REQ-032 rst SHALL set state IDLE, step 0, counter 0, done 0, loop 0, and all registers, table entries and SAMPLE to 0; outputs busy, irq, strobes, portDataOut 0.
REQ-033 rst mid-sequence SHALL abandon the sequence with no further port strobes; rst SHALL take priority over all bus writes.

Verification
REQ-034 LENGTH=2, DIRECTION=0xFF, VALUE0=0x11, VALUE1=0x22, DELAY0=3, DELAY1=0, start -> writeDirection 0xFF at T+1, writeIO 0x11 at T+2, 0x22 at T+7, done/irq at T+10, busy low.
REQ-035 LENGTH=0, start -> no strobes, busy stays 0; LENGTH=12 -> exactly 8 writeIO strobes.
REQ-036 loop=1, LENGTH=2, DELAY=0 -> writes 0x11,0x22,0x11,... every 2 cycles, irq never asserts; abort -> IDLE next cycle, done 0.
REQ-037 portDataIn=0xA5A5 at step 0 WRITE cycle -> SAMPLE reads 0xA5A5; start during busy -> sequence unchanged.
REQ-038 rst asserted during WAIT -> next cycle busy 0, all registers read 0, no further strobes.

Source files
------------

// File: rtl/port_sequencer.sv
// port_sequencer: CPU-programmed sequencer that replays a table of values onto a digital port
module port_sequencer #(
  parameter int STEPS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipSelect,
  input  logic        writeEnable,
  input  logic [4:0]  address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        portChipSelect,
  output logic        portWriteIO,
  output logic        portWriteDirection,
  output logic [31:0] portDataOut,
  input  logic [31:0] portDataIn,
  output logic        busy,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, DIR, WRITE, WAIT} state_t;
  state_t state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [3:0]  len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        loop_q;
  logic [3:0]  length_q;
  logic [31:0] dir_q, sample_q;
  logic [31:0] value_q [STEPS];
  logic [15:0] delay_q [STEPS];
  logic wr, ctrl_wr, abort, start, last, finish;
  assign wr      = chipSelect & writeEnable;
  assign ctrl_wr = wr && address == 5'd0;
  assign abort   = ctrl_wr & dataIn[2];
  assign start   = ctrl_wr && dataIn[0] && !dataIn[2] && state_q == IDLE && length_q != 4'd0;
  assign last    = {1'b0, step_q} == len_q - 4'd1;
  assign finish  = state_q == WAIT && cnt_q == 16'd0 && last && !loop_q;
  assign busy    = state_q != IDLE;
  assign irq     = done_q;
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    len_d = len_q;
    cnt_d = cnt_q;
    done_d = done_q;
    portChipSelect = 1'b0;
    portWriteIO = 1'b0;
    portWriteDirection = 1'b0;
    portDataOut = 32'd0;
    case (state_q)
      IDLE: if (start) begin
        state_d = DIR;
        step_d = 3'd0;
        len_d = length_q > 4'd8 ? 4'd8 : length_q;
      end
      DIR: begin
        portChipSelect = 1'b1;
        portWriteDirection = 1'b1;
        portDataOut = dir_q;
        state_d = WRITE;
      end
      WRITE: begin
        portChipSelect = 1'b1;
        portWriteIO = 1'b1;
        portDataOut = value_q[step_q];
        cnt_d = delay_q[step_q];
        state_d = WAIT;
      end
      WAIT: if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else if (!last) begin
          step_d = step_q + 3'd1;
          state_d = WRITE;
        end else if (loop_q) begin
          step_d = 3'd0;
          state_d = WRITE;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = finish ? 1'b1 : ctrl_wr ? 1'b0 : done_q;
    if (abort) begin
      state_d = IDLE;
      done_d = 1'b0;
    end
    // An abort or reset in flight must never let a strobe reach the port
    if (abort || rst) begin
      portChipSelect = 1'b0;
      portWriteIO = 1'b0;
      portWriteDirection = 1'b0;
      portDataOut = 32'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q <= 3'd0;
      len_q <= 4'd0;
      cnt_q <= 16'd0;
      done_q <= 1'b0;
      loop_q <= 1'b0;
      length_q <= 4'd0;
      dir_q <= 32'd0;
      sample_q <= 32'd0;
      for (int i = 0; i < STEPS; i++) begin
        value_q[i] <= 32'd0;
        delay_q[i] <= 16'd0;
      end
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      if (state_q == WRITE && !abort) sample_q <= portDataIn;
      if (ctrl_wr) loop_q <= dataIn[1];
      if (wr && address == 5'd1) length_q <= dataIn[3:0];
      if (wr && address == 5'd2) dir_q <= dataIn;
      if (wr && address[4:3] == 2'b01) value_q[address[2:0]] <= dataIn;
      if (wr && address[4:3] == 2'b10) delay_q[address[2:0]] <= dataIn[15:0];
    end
  end
  always_comb begin
    dataOut = address == 5'd0 ? {25'd0, step_q, 1'b0, loop_q, done_q, busy}
            : address == 5'd1 ? {28'd0, length_q}
            : address == 5'd2 ? dir_q
            : address == 5'd3 ? sample_q
            : address[4:3] == 2'b01 ? value_q[address[2:0]]
            : address[4:3] == 2'b10 ? {16'd0, delay_q[address[2:0]]}
            : 32'd0;
  end
endmodule

// File: tb/tb_port_sequencer.sv
// tb_port_sequencer: directed self-checking bench for port_sequencer
module tb_port_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chipSelect = 1'b0;
  logic        writeEnable = 1'b0;
  logic [4:0]  address = 5'd0;
  logic [31:0] dataIn = 32'd0;
  logic [31:0] dataOut;
  logic        portChipSelect, portWriteIO, portWriteDirection;
  logic [31:0] portDataOut;
  logic [31:0] portDataIn = 32'd0;
  logic        busy, irq;
  int n_tests = 0;
  int n_fail = 0;
  int io_cnt = 0;
  int snap;

  port_sequencer dut (
    .clk(clk), .rst(rst), .chipSelect(chipSelect), .writeEnable(writeEnable),
    .address(address), .dataIn(dataIn), .dataOut(dataOut),
    .portChipSelect(portChipSelect), .portWriteIO(portWriteIO),
    .portWriteDirection(portWriteDirection), .portDataOut(portDataOut),
    .portDataIn(portDataIn), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (portWriteIO === 1'b1) io_cnt <= io_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    chipSelect = 1'b1;
    writeEnable = 1'b1;
    address = a;
    dataIn = d;
    step();
    chipSelect = 1'b0;
    writeEnable = 1'b0;
    address = 5'd0;
    dataIn = 32'd0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = dataOut;
    address = 5'd0;
  endtask

  task automatic chk_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) step();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_strobes", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'd0);
    chk("rst_pdo", portDataOut, 32'd0);
    chk_rd("rst_ctrl", 5'd0, 32'd0);
    chk_rd("rst_value0", 5'd8, 32'd0);

    bus_wr(5'd1, 32'd2);
    bus_wr(5'd2, 32'hFF);
    bus_wr(5'd8, 32'h11);
    bus_wr(5'd9, 32'h22);
    bus_wr(5'd16, 32'd3);
    bus_wr(5'd17, 32'd0);
    chk_rd("rd_delay0", 5'd16, 32'd3);
    chk_rd("rd_unmapped", 5'd5, 32'd0);
    portDataIn = 32'hA5A5;
    snap = io_cnt;
    bus_wr(5'd0, 32'h1);
    chk("t1_dir_strobe", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'h5);
    chk("t1_dir_data", portDataOut, 32'hFF);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t2_io_strobe", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'h6);
    chk("t2_io_data", portDataOut, 32'h11);
    step();
    chk("t3_wait_strobes", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'd0);
    chk("t3_wait_pdo", portDataOut, 32'd0);
    chk_rd("t3_sample", 5'd3, 32'hA5A5);
    portDataIn = 32'h5A5A;
    bus_wr(5'd0, 32'h1);
    chk_rd("t4_ctrl_busy", 5'd0, 32'h1);
    repeat (3) step();
    chk("t7_io_strobe", {31'd0, portWriteIO}, 32'd1);
    chk("t7_io_data", portDataOut, 32'h22);
    repeat (3) step();
    chk("t10_irq", {31'd0, irq}, 32'd1);
    chk("t10_busy", {31'd0, busy}, 32'd0);
    chk_rd("t10_ctrl", 5'd0, 32'h12);
    chk_rd("t10_sample", 5'd3, 32'h5A5A);
    chk("t_io_count", io_cnt - snap, 32'd2);
    bus_wr(5'd0, 32'h0);
    chk("ctrl_wr_clears_done", {31'd0, irq}, 32'd0);

    bus_wr(5'd1, 32'd0);
    snap = io_cnt;
    bus_wr(5'd0, 32'h1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    repeat (4) step();
    chk("len0_no_strobes", io_cnt - snap, 32'd0);

    bus_wr(5'd1, 32'd12);
    snap = io_cnt;
    bus_wr(5'd0, 32'h1);
    wait_idle("len12_finish");
    chk("len12_io_count", io_cnt - snap, 32'd8);
    chk_rd("len12_ctrl", 5'd0, 32'h72);

    bus_wr(5'd1, 32'd2);
    bus_wr(5'd16, 32'd0);
    bus_wr(5'd0, 32'h3);
    step();
    chk("loop_w0", portDataOut, 32'h11);
    repeat (2) step();
    chk("loop_w1", portDataOut, 32'h22);
    repeat (2) step();
    chk("loop_w2", portDataOut, 32'h11);
    chk("loop_w2_strobe", {31'd0, portWriteIO}, 32'd1);
    repeat (7) step();
    chk("loop_no_irq", {31'd0, irq}, 32'd0);
    step();
    chk("loop_pre_abort_io", {31'd0, portWriteIO}, 32'd1);
    chipSelect = 1'b1;
    writeEnable = 1'b1;
    address = 5'd0;
    dataIn = 32'h4;
    #1;
    chk("abort_no_strobe", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'd0);
    step();
    chipSelect = 1'b0;
    writeEnable = 1'b0;
    dataIn = 32'd0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    bus_wr(5'd0, 32'h5);
    chk("abort_beats_start", {31'd0, busy}, 32'd0);

    bus_wr(5'd0, 32'h3);
    snap = io_cnt;
    step();
    bus_wr(5'd0, 32'h0);
    wait_idle("unloop_finish");
    chk("unloop_io_count", io_cnt - snap, 32'd2);
    chk("unloop_irq", {31'd0, irq}, 32'd1);

    bus_wr(5'd16, 32'd20);
    bus_wr(5'd0, 32'h1);
    repeat (2) step();
    chk("pre_rst_wait", {29'd0, portChipSelect, portWriteIO, portWriteDirection}, 32'd0);
    rst = 1'b1;
    chipSelect = 1'b1;
    writeEnable = 1'b1;
    address = 5'd1;
    dataIn = 32'd5;
    step();
    rst = 1'b0;
    chipSelect = 1'b0;
    writeEnable = 1'b0;
    dataIn = 32'd0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("mid_rst_ctrl", 5'd0, 32'd0);
    chk_rd("mid_rst_length", 5'd1, 32'd0);
    chk_rd("mid_rst_dir", 5'd2, 32'd0);
    chk_rd("mid_rst_sample", 5'd3, 32'd0);
    chk_rd("mid_rst_value1", 5'd9, 32'd0);
    chk_rd("mid_rst_delay0", 5'd16, 32'd0);
    snap = io_cnt;
    repeat (10) step();
    chk("mid_rst_no_strobes", io_cnt - snap, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
